dmem_lsu: RTL and testbench
===========================

# dmem_lsu

Load/store unit between the execute stage and the single-port synchronous data SRAM (CSN/WEN active-low, one-cycle registered read). Accepts one byte/halfword/word request at a time and drives the SRAM port. Returns sign- or zero-extended load data. Sub-word stores use a read-modify-write sequence, because the SRAM has no byte enables.

## Interface
- AW, 10, SRAM word-address width; byte address is AW+2 bits
- CLK  in  1  clock, all state on rising edge
- RSTN  in  1  reset, asynchronous, active-low
- REQ  in  1  request valid
- RDY  out  1  ready; high only in IDLE
- WE  in  1  1 = store, 0 = load
- SIZE  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- SIGNED  in  1  loads: 1 sign-extend, 0 zero-extend
- ADDR  in  AW+2  byte address
- WDATA  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- ACK  out  1  one-cycle completion pulse (loads, stores, errors)
- ERR  out  1  valid with ACK: misaligned or illegal SIZE
- RDATA  out  32  load result, valid with ACK on loads; otherwise holds last load value
- M_CSN  out  1  SRAM chip select, active-low
- M_WEN  out  1  SRAM write enable, active-low (1 = read)
- M_A  out  AW  SRAM word address = latched ADDR[AW+1:2]
- M_DI  out  32  SRAM write data
- M_DOUT  in  32  SRAM read data, valid the cycle after the read edge

## Operation
- Handshake:
  - The request is accepted on the rising edge where REQ&RDY=1.
  - ADDR, WE, SIZE, SIGNED and WDATA are latched at that edge.
  - REQ while RDY=0 is ignored.
- Misaligned when any of: SIZE=01 with ADDR[0]=1; SIZE=10 with ADDR[1:0]≠0; SIZE=11. A misaligned request makes no SRAM access (M_CSN stays 1).
- States and transitions (ACK/ERR/RDATA registered, set on the edge entering IDLE):
  - IDLE: M_CSN=1. On accept:
    - misaligned → IDLE with ACK=1, ERR=1
    - load → RD
    - word store → WR
    - byte/half store → RMR
  - RD: M_CSN=0, M_WEN=1 → LDW.
  - LDW: M_CSN=1. Extracted data is captured into RDATA; → IDLE with ACK=1, ERR=0.
  - WR: M_CSN=0, M_WEN=0, M_DI=WDATA → IDLE with ACK=1.
  - RMR: M_CSN=0, M_WEN=1 → RMM.
  - RMM: M_CSN=1. The merged word (M_DOUT with the target lane(s) replaced) is registered → RMW.
  - RMW: M_CSN=0, M_WEN=0, M_DI=merged → IDLE with ACK=1.
- Lanes are little-endian:
  - byte k = bits [8k+7:8k], k=ADDR[1:0]
  - half h = bits [16h+15:16h], h=ADDR[1]
- Extension:
  - SIGNED=1 replicates bit 7 (byte) or bit 15 (half) into the upper bits.
  - SIGNED=0 zero-fills.
  - Word loads pass through.
- M_WEN=1 and M_DI=0 whenever no write is driven. M_A always reflects the latched address.
- ACK is high exactly one cycle, in IDLE, so RDY=1 in the ACK cycle. A REQ in that cycle is accepted (back-to-back).
- RDATA is not modified by stores or errors.

## Timing
- Accept edge E0. ACK high in the cycle following:
  - E0 for errors (latency 1)
  - E1 for word store (latency 2)
  - E2 for load (latency 3)
  - E3 for sub-word store (latency 4)
- The SRAM samples M_CSN/M_WEN/M_A/M_DI on the edge leaving RD/WR/RMR/RMW.
- Reset (RSTN=0, asynchronous) forces:
  - state=IDLE, RDY=1
  - ACK=0, ERR=0, RDATA=0
  - M_CSN=1, M_WEN=1, M_DI=0
- Reset asserted during WR or RMW deasserts M_CSN immediately, so no SRAM write occurs. A sub-word store interrupted in RMR/RMM leaves memory unchanged.
- After RSTN rises, the first edge may accept a request.

## Test plan
- Word store then load: store 0x11223344 @0x10, load word @0x10 → ACK 2 then 3 cycles after accept, RDATA=0x11223344, ERR=0.
- Byte RMW: word @0x04=0x11223344, byte store 0xAB @0x05 → 4-cycle latency, one SRAM read then one write, word becomes 0x1122AB44.
- Extension: word @0x08=0x0000807F:
  - signed byte @0x09 → 0xFFFFFF80
  - unsigned byte @0x09 → 0x00000080
  - signed half @0x08 → 0xFFFF807F
- Misalign: half @0x03, word @0x06, SIZE=11 → each ACK=1, ERR=1 one cycle after accept; M_CSN never 0; RDATA unchanged.
- Reset mid-RMW: byte store 0xFF @0x00 to word 0x12345678, RSTN low in RMM → RDY=1, ACK=0, RDATA=0; subsequent load @0x00 returns 0x12345678.
- Back-to-back: REQ held high for store then load; second request accepted in the ACK cycle of the first; REQ during RDY=0 has no effect.

Source files
------------

// File: rtl/dmem_lsu_if.sv
// Bus bundle for the data-memory load/store unit.
// Carries the execute-stage request/response handshake and the
// single-port SRAM pins. The LSU uses the slave view; the execute stage
// and SRAM side (or a bench) use the master view.
interface dmem_lsu_if #(
  parameter int AW = 10
);
  // Execute-stage request side
  logic          REQ;
  logic          RDY;
  logic          WE;
  logic [1:0]    SIZE;
  logic          SIGNED;
  logic [AW+1:0] ADDR;
  logic [31:0]   WDATA;
  logic          ACK;
  logic          ERR;
  logic [31:0]   RDATA;

  // SRAM side (active-low controls, one-cycle registered read)
  logic          M_CSN;
  logic          M_WEN;
  logic [AW-1:0] M_A;
  logic [31:0]   M_DI;
  logic [31:0]   M_DOUT;

  modport slave (
    input  REQ, WE, SIZE, SIGNED, ADDR, WDATA, M_DOUT,
    output RDY, ACK, ERR, RDATA, M_CSN, M_WEN, M_A, M_DI
  );

  modport master (
    output REQ, WE, SIZE, SIGNED, ADDR, WDATA, M_DOUT,
    input  RDY, ACK, ERR, RDATA, M_CSN, M_WEN, M_A, M_DI
  );
endinterface

// File: rtl/dmem_lsu.sv
// Load/store unit in front of a single-port synchronous data SRAM.
// One request at a time: byte/half/word loads with sign or zero extension,
// word stores written directly, sub-word stores done as read-modify-write
// because the SRAM has no byte enables. Misaligned or illegal-size requests
// are answered with ACK+ERR without touching the SRAM.
module dmem_lsu #(
  parameter int AW = 10
) (
  input  logic          CLK,
  input  logic          RSTN,
  dmem_lsu_if.slave     bus
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    LDW,
    WR,
    RMR,
    RMM,
    RMW
  } state_t;

  state_t        state;

  // Request fields latched on the accept edge
  logic [AW+1:0] addr_q;
  logic [1:0]    size_q;
  logic          signed_q;
  logic [15:0]   wdata_q;

  // Registered outputs
  logic          ack_q;
  logic          err_q;
  logic [31:0]   rdata_q;
  logic          csn_q;
  logic          wen_q;
  logic [31:0]   di_q;

  // Combinational helpers
  logic          misaligned;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;
  logic [31:0]   load_ext;
  logic [31:0]   merged;

  assign bus.RDY   = (state == IDLE);
  assign bus.ACK   = ack_q;
  assign bus.ERR   = err_q;
  assign bus.RDATA = rdata_q;
  assign bus.M_CSN = csn_q;
  assign bus.M_WEN = wen_q;
  assign bus.M_A   = addr_q[AW+1:2];
  assign bus.M_DI  = di_q;

  // Alignment check on the live request, used only on the accept edge
  always_comb begin
    misaligned = 1'b0;
    case (bus.SIZE)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = bus.ADDR[0];
      2'b10:   misaligned = |bus.ADDR[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  // Pick the addressed byte and halfword lanes out of the SRAM read word
  always_comb begin
    lane_b = 8'h00;
    case (addr_q[1:0])
      2'd0:    lane_b = bus.M_DOUT[7:0];
      2'd1:    lane_b = bus.M_DOUT[15:8];
      2'd2:    lane_b = bus.M_DOUT[23:16];
      default: lane_b = bus.M_DOUT[31:24];
    endcase
    lane_h = addr_q[1] ? bus.M_DOUT[31:16] : bus.M_DOUT[15:0];
  end

  // Sign- or zero-extend the selected lane; words pass straight through
  always_comb begin
    load_ext = bus.M_DOUT;
    case (size_q)
      2'b00:   load_ext = {{24{signed_q & lane_b[7]}}, lane_b};
      2'b01:   load_ext = {{16{signed_q & lane_h[15]}}, lane_h};
      default: load_ext = bus.M_DOUT;
    endcase
  end

  // Replace the target lane(s) of the old word with the store data
  always_comb begin
    merged = bus.M_DOUT;
    if (size_q == 2'b00) begin
      case (addr_q[1:0])
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else begin
      if (addr_q[1]) begin
        merged[31:16] = wdata_q;
      end else begin
        merged[15:0] = wdata_q;
      end
    end
  end

  // Sequencer: accepts requests in IDLE and drives the SRAM one access per state;
  // reset drops M_CSN at once so an in-flight write never reaches the SRAM
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state    <= IDLE;
      addr_q   <= '0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      wdata_q  <= 16'h0000;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 32'h0000_0000;
      csn_q    <= 1'b1;
      wen_q    <= 1'b1;
      di_q     <= 32'h0000_0000;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.REQ) begin
            addr_q   <= bus.ADDR;
            size_q   <= bus.SIZE;
            signed_q <= bus.SIGNED;
            wdata_q  <= bus.WDATA[15:0];
            if (misaligned) begin
              ack_q <= 1'b1;
              err_q <= 1'b1;
            end else if (!bus.WE) begin
              state <= RD;
              csn_q <= 1'b0;
              wen_q <= 1'b1;
            end else if (bus.SIZE == 2'b10) begin
              state <= WR;
              csn_q <= 1'b0;
              wen_q <= 1'b0;
              di_q  <= bus.WDATA;
            end else begin
              state <= RMR;
              csn_q <= 1'b0;
              wen_q <= 1'b1;
            end
          end
        end
        RD: begin
          csn_q <= 1'b1;
          state <= LDW;
        end
        LDW: begin
          rdata_q <= load_ext;
          ack_q   <= 1'b1;
          state   <= IDLE;
        end
        WR: begin
          csn_q <= 1'b1;
          wen_q <= 1'b1;
          di_q  <= 32'h0000_0000;
          ack_q <= 1'b1;
          state <= IDLE;
        end
        RMR: begin
          csn_q <= 1'b1;
          state <= RMM;
        end
        RMM: begin
          csn_q <= 1'b0;
          wen_q <= 1'b0;
          di_q  <= merged;
          state <= RMW;
        end
        RMW: begin
          csn_q <= 1'b1;
          wen_q <= 1'b1;
          di_q  <= 32'h0000_0000;
          ack_q <= 1'b1;
          state <= IDLE;
        end
        default: begin
          csn_q <= 1'b1;
          wen_q <= 1'b1;
          di_q  <= 32'h0000_0000;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a behavioural single-port SRAM attached.
module tb_dmem_lsu;

  localparam int AW = 10;

  logic CLK;
  logic RSTN;
  int   testCount;
  int   failCount;
  int   rdCount;
  int   wrCount;
  int   lat;
  int   rdBefore;
  int   wrBefore;
  logic [31:0] rdataBefore;
  logic [31:0] sramDout;
  logic [31:0] mem [0:(1<<AW)-1];

  dmem_lsu_if #(.AW(AW)) bus ();

  dmem_lsu #(.AW(AW)) dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign bus.M_DOUT = sramDout;

  // Synchronous SRAM: samples controls on the rising edge, read data one cycle later
  always @(posedge CLK) begin
    if (!bus.M_CSN) begin
      if (!bus.M_WEN) begin
        mem[bus.M_A] <= bus.M_DI;
        wrCount++;
      end else begin
        sramDout <= mem[bus.M_A];
        rdCount++;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Present one request, release REQ after the accept edge, then count cycles to ACK
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic sgn,
                               input logic [AW+1:0] addr, input logic [31:0] wdata,
                               output int latency);
    @(negedge CLK);
    bus.REQ    = 1'b1;
    bus.WE     = we;
    bus.SIZE   = size;
    bus.SIGNED = sgn;
    bus.ADDR   = addr;
    bus.WDATA  = wdata;
    @(posedge CLK);
    @(negedge CLK);
    bus.REQ = 1'b0;
    latency = 1;
    while (!bus.ACK && latency < 20) begin
      @(negedge CLK);
      latency++;
    end
    if (!bus.ACK) latency = 99;
  endtask

  initial begin
    testCount  = 0;
    failCount  = 0;
    rdCount    = 0;
    wrCount    = 0;
    sramDout   = 32'h0;
    RSTN       = 1'b0;
    bus.REQ    = 1'b0;
    bus.WE     = 1'b0;
    bus.SIZE   = 2'b00;
    bus.SIGNED = 1'b0;
    bus.ADDR   = '0;
    bus.WDATA  = 32'h0;

    // Reset values
    @(negedge CLK);
    @(negedge CLK);
    checkOutput("rst_rdy",   32'(bus.RDY),   32'd1);
    checkOutput("rst_ack",   32'(bus.ACK),   32'd0);
    checkOutput("rst_err",   32'(bus.ERR),   32'd0);
    checkOutput("rst_rdata", bus.RDATA,      32'h0);
    checkOutput("rst_csn",   32'(bus.M_CSN), 32'd1);
    checkOutput("rst_wen",   32'(bus.M_WEN), 32'd1);
    checkOutput("rst_di",    bus.M_DI,       32'h0);
    RSTN = 1'b1;

    // Word store then word load
    applyStimulus(1'b1, 2'b10, 1'b0, 12'h010, 32'h1122_3344, lat);
    checkOutput("wst_lat", 32'(lat), 32'd2);
    checkOutput("wst_err", 32'(bus.ERR), 32'd0);
    checkOutput("wst_mem", mem[4], 32'h1122_3344);
    applyStimulus(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, lat);
    checkOutput("wld_lat", 32'(lat), 32'd3);
    checkOutput("wld_err", 32'(bus.ERR), 32'd0);
    checkOutput("wld_data", bus.RDATA, 32'h1122_3344);

    // Byte read-modify-write
    applyStimulus(1'b1, 2'b10, 1'b0, 12'h004, 32'h1122_3344, lat);
    rdBefore = rdCount;
    wrBefore = wrCount;
    applyStimulus(1'b1, 2'b00, 1'b0, 12'h005, 32'h0000_00AB, lat);
    checkOutput("bst_lat", 32'(lat), 32'd4);
    checkOutput("bst_reads", 32'(rdCount - rdBefore), 32'd1);
    checkOutput("bst_writes", 32'(wrCount - wrBefore), 32'd1);
    checkOutput("bst_mem", mem[1], 32'h1122_AB44);
    checkOutput("bst_rdata_kept", bus.RDATA, 32'h1122_3344);

    // Halfword read-modify-write into the upper lane
    applyStimulus(1'b1, 2'b10, 1'b0, 12'h00C, 32'h1234_5678, lat);
    applyStimulus(1'b1, 2'b01, 1'b0, 12'h00E, 32'h0000_BEEF, lat);
    checkOutput("hst_lat", 32'(lat), 32'd4);
    checkOutput("hst_mem", mem[3], 32'hBEEF_5678);

    // Load extension
    applyStimulus(1'b1, 2'b10, 1'b0, 12'h008, 32'h0000_807F, lat);
    applyStimulus(1'b0, 2'b00, 1'b1, 12'h009, 32'h0, lat);
    checkOutput("ldb_signed", bus.RDATA, 32'hFFFF_FF80);
    applyStimulus(1'b0, 2'b00, 1'b0, 12'h009, 32'h0, lat);
    checkOutput("ldb_unsigned", bus.RDATA, 32'h0000_0080);
    applyStimulus(1'b0, 2'b01, 1'b1, 12'h008, 32'h0, lat);
    checkOutput("ldh_signed", bus.RDATA, 32'hFFFF_807F);
    applyStimulus(1'b0, 2'b00, 1'b1, 12'h008, 32'h0, lat);
    checkOutput("ldb_signed_pos", bus.RDATA, 32'h0000_007F);
    applyStimulus(1'b0, 2'b01, 1'b0, 12'h00E, 32'h0, lat);
    checkOutput("ldh_unsigned_hi", bus.RDATA, 32'h0000_BEEF);

    // Misaligned and illegal-size requests
    rdataBefore = bus.RDATA;
    rdBefore = rdCount;
    wrBefore = wrCount;
    applyStimulus(1'b0, 2'b01, 1'b0, 12'h003, 32'h0, lat);
    checkOutput("mis_half_lat", 32'(lat), 32'd1);
    checkOutput("mis_half_err", 32'(bus.ERR), 32'd1);
    applyStimulus(1'b1, 2'b10, 1'b0, 12'h006, 32'hDEAD_BEEF, lat);
    checkOutput("mis_word_lat", 32'(lat), 32'd1);
    checkOutput("mis_word_err", 32'(bus.ERR), 32'd1);
    applyStimulus(1'b0, 2'b11, 1'b0, 12'h000, 32'h0, lat);
    checkOutput("mis_size_lat", 32'(lat), 32'd1);
    checkOutput("mis_size_err", 32'(bus.ERR), 32'd1);
    checkOutput("mis_rdata_kept", bus.RDATA, rdataBefore);
    checkOutput("mis_no_access", 32'((rdCount - rdBefore) + (wrCount - wrBefore)), 32'd0);

    // Reset while a byte store sits in RMM
    applyStimulus(1'b1, 2'b10, 1'b0, 12'h000, 32'h1234_5678, lat);
    wrBefore = wrCount;
    @(negedge CLK);
    bus.REQ    = 1'b1;
    bus.WE     = 1'b1;
    bus.SIZE   = 2'b00;
    bus.SIGNED = 1'b0;
    bus.ADDR   = 12'h000;
    bus.WDATA  = 32'h0000_00FF;
    @(posedge CLK);
    @(negedge CLK);
    bus.REQ = 1'b0;
    @(negedge CLK);
    RSTN = 1'b0;
    #1;
    checkOutput("rmw_rst_rdy",   32'(bus.RDY),   32'd1);
    checkOutput("rmw_rst_ack",   32'(bus.ACK),   32'd0);
    checkOutput("rmw_rst_rdata", bus.RDATA,      32'h0);
    checkOutput("rmw_rst_csn",   32'(bus.M_CSN), 32'd1);
    @(negedge CLK);
    RSTN = 1'b1;
    checkOutput("rmw_rst_nowrite", 32'(wrCount - wrBefore), 32'd0);
    checkOutput("rmw_rst_mem", mem[0], 32'h1234_5678);
    applyStimulus(1'b0, 2'b10, 1'b0, 12'h000, 32'h0, lat);
    checkOutput("rmw_rst_load", bus.RDATA, 32'h1234_5678);

    // Back-to-back with REQ held high; load fields shown while busy are ignored
    wrBefore = wrCount;
    @(negedge CLK);
    bus.REQ    = 1'b1;
    bus.WE     = 1'b1;
    bus.SIZE   = 2'b10;
    bus.SIGNED = 1'b0;
    bus.ADDR   = 12'h020;
    bus.WDATA  = 32'hCAFE_F00D;
    @(posedge CLK);
    @(negedge CLK);
    checkOutput("b2b_busy_rdy", 32'(bus.RDY), 32'd0);
    bus.WE    = 1'b0;
    bus.WDATA = 32'h0;
    @(negedge CLK);
    checkOutput("b2b_st_ack", 32'(bus.ACK), 32'd1);
    checkOutput("b2b_st_rdy", 32'(bus.RDY), 32'd1);
    @(posedge CLK);
    @(negedge CLK);
    bus.REQ = 1'b0;
    checkOutput("b2b_ld_accepted", 32'(bus.RDY), 32'd0);
    checkOutput("b2b_ack_single", 32'(bus.ACK), 32'd0);
    lat = 1;
    while (!bus.ACK && lat < 20) begin
      @(negedge CLK);
      lat++;
    end
    if (!bus.ACK) lat = 99;
    checkOutput("b2b_ld_lat", 32'(lat), 32'd3);
    checkOutput("b2b_ld_data", bus.RDATA, 32'hCAFE_F00D);
    checkOutput("b2b_one_write", 32'(wrCount - wrBefore), 32'd1);
    checkOutput("b2b_mem", mem[8], 32'hCAFE_F00D);
    @(negedge CLK);
    checkOutput("b2b_idle_after", 32'(bus.RDY), 32'd1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
